// File: rtl/booth_mult.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult
// Purpose  : Sequential radix-2 Booth multiplier. Two's-complement WIDTH-bit
//            operands, one add/shift step per cycle, start/done handshake.
//            Define BOOTH_SIGN_SEL_EN to add the sgn port (unsigned mode).
// Revision : 1.0 - initial release
// ============================================================================
module booth_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef BOOTH_SIGN_SEL_EN
  input  logic               sgn,
`endif
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int c_AW = WIDTH + 1;
`ifdef BOOTH_SIGN_SEL_EN
  localparam int c_QW = WIDTH + 1;
`else
  localparam int c_QW = WIDTH;
`endif
  localparam int c_CW = $clog2(WIDTH + 2);
  localparam logic [c_CW-1:0] c_STEPS = c_CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [c_AW-1:0]    a_q, a_d;
  logic [c_QW-1:0]    q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [c_AW-1:0]    m_q, m_d;
  logic [c_CW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [c_AW-1:0]    w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_load;
`ifdef BOOTH_SIGN_SEL_EN
  logic               sgn_q, sgn_d;
`endif

  always_comb begin
    w_sum = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   w_sum = a_q + m_q;
      2'b10:   w_sum = a_q - m_q;
      default: w_sum = a_q;
    endcase
  end

  // Product slice of the post-shift {A,Q}; in signed mode the extra Q bit
  // still holds an unconsumed multiplier bit, so the window sits one higher.
`ifdef BOOTH_SIGN_SEL_EN
  assign w_prod = sgn_q ? {w_sum, q_q[c_QW-1:2]}
                        : {w_sum[WIDTH-1:0], q_q[c_QW-1:1]};
`else
  assign w_prod = {w_sum, q_q[c_QW-1:1]};
`endif

  assign w_load = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
`ifdef BOOTH_SIGN_SEL_EN
    sgn_d   = sgn_q;
`endif
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_CALC: begin
        busy  = 1'b1;
        a_d   = {w_sum[c_AW-1], w_sum[c_AW-1:1]};
        q_d   = {w_sum[0], q_q[c_QW-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - c_CW'(1);
        if (cnt_q == c_CW'(1)) begin
          prod_d  = w_prod;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (w_load) begin
      state_d = S_CALC;
      a_d     = '0;
      qm1_d   = 1'b0;
`ifdef BOOTH_SIGN_SEL_EN
      sgn_d   = sgn;
      if (sgn) begin
        q_d   = {multiplier[WIDTH-1], multiplier};
        m_d   = {multiplicand[WIDTH-1], multiplicand};
        cnt_d = c_STEPS;
      end else begin
        q_d   = {1'b0, multiplier};
        m_d   = {1'b0, multiplicand};
        cnt_d = c_STEPS + c_CW'(1);
      end
`else
      q_d     = multiplier;
      m_d     = {multiplicand[WIDTH-1], multiplicand};
      cnt_d   = c_STEPS;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
`ifdef BOOTH_SIGN_SEL_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
`ifdef BOOTH_SIGN_SEL_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign product = prod_q;

endmodule
`default_nettype wire

// File: doc/booth_mult.md
# booth_mult

Parametrised sequential radix-2 Booth multiplier, successor of the fixed 4-bit A/Q register datapath used in the Booth design. It packages the accumulator (A), multiplier (Q), Q₋₁ bit, multiplicand (M), step counter and control FSM into one block. It multiplies two WIDTH-bit two's-complement operands in WIDTH add/shift steps behind a start/done handshake. It is the arithmetic core instantiated by the multiplier top level.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; clears all state.
- start  in  1  request pulse; sampled only when busy=0.
- multiplicand  in  WIDTH  operand M; captured on the accepting edge.
- multiplier  in  WIDTH  operand Q; captured on the accepting edge.
- busy  out  1  high while steps are in progress.
- done  out  1  one-cycle pulse; product is valid and updated.
- product  out  2*WIDTH  registered result; held until the next completion.
- sgn  in  1  (only with BOOTH_SIGN_SEL_EN) 1 = signed, 0 = unsigned; captured with the operands.

## Operation
- Internal state:
  - A: WIDTH+1 bits, so A−M cannot overflow for M = −2^(WIDTH−1).
  - Q: multiplier register.
  - q_m1: the Q₋₁ bit.
  - M: WIDTH+1 bits, multiplicand sign-extended.
  - cnt: $clog2(WIDTH+2) bits.
- FSM states: IDLE, CALC, DONE.
  - IDLE: start=1 → load A=0, Q=multiplier, q_m1=0, M=sext(multiplicand), cnt=WIDTH; go to CALC.
  - CALC: one step per cycle, then cnt−1.
    - {Q[0],q_m1}=01 → A=A+M; =10 → A=A−M; 00/11 → A unchanged.
    - Then arithmetic right shift of {A,Q,q_m1} by one, with A's MSB replicated.
    - On the step where cnt=1: product ← low 2*WIDTH bits of the shifted {A,Q}; go to DONE.
  - DONE: done=1 for this cycle only; go to IDLE. If start=1 in DONE, accept it exactly as in IDLE and go to CALC (back-to-back operation).
- busy=1 exactly in CALC. start while busy=1 is ignored, and operand inputs are don't-care.
- Arithmetic is modulo 2^(WIDTH+1) in A. The final 2*WIDTH-bit product is exact for every signed operand pair, including −2^(WIDTH−1) × −2^(WIDTH−1).

## Timing
- Reset (reset=0, async, any state) gives: state=IDLE, busy=0, done=0, product=0, and A/Q/q_m1/M/cnt=0.
- A reset asserted mid-operation aborts it with no done pulse. The first start after reset release is accepted normally.
- start accepted at edge E0:
  - busy=1 after E0.
  - Steps occur at edges E1..E_WIDTH.
  - product is updated at E_WIDTH.
  - busy=0 and done=1 from E_WIDTH until E_WIDTH+1.
- Latency from accepting edge to done is WIDTH cycles. Maximum throughput is one result per WIDTH+1 cycles.
- product changes only at completion edges and at reset.

## Configuration
- BOOTH_SIGN_SEL_EN undefined:
  - No sgn port.
  - All operations are signed.
  - Latency is exactly WIDTH steps.
- BOOTH_SIGN_SEL_EN defined:
  - The sgn port exists.
  - sgn=1 behaves exactly as the undefined case.
  - sgn=0 treats both operands as unsigned:
    - M and the multiplier are zero-extended to WIDTH+1 bits.
    - The Q path is WIDTH+1 bits, and cnt loads WIDTH+1.
    - product is the low 2*WIDTH bits after WIDTH+1 steps.
    - done arrives one cycle later than a signed operation.

## Test plan
- WIDTH=4, M=3, Q=−2 (4'hE) → after 4 steps, done pulses one cycle; product=8'hFA (−6); busy high for exactly 4 cycles.
- WIDTH=4, M=−8, Q=−8 → product=8'h40 (+64), with no overflow corruption. Then M=−8, Q=7 → product=8'hC8 (−56).
- WIDTH=4, M=5, Q=6, then a second start pulse 2 cycles after acceptance with M=1, Q=1 → second start ignored; product=8'h1E (30).
- WIDTH=4, start in the DONE cycle with M=−1, Q=−1 → first result 8'h1E is held; second done 5 cycles later with product=8'h01.
- WIDTH=8, reset pulsed low during step 3 of 100×−100 → busy, done and product go to 0 immediately; no done pulse. Then 100×−100 → product=16'hD8F0 (−10000).
- With BOOTH_SIGN_SEL_EN, WIDTH=4, sgn=0, M=15, Q=15 → done after 5 steps; product=8'hE1 (225). Same operands with sgn=1 → product=8'h01 after 4 steps.
